// File: rtl/uart_apb_host_pkg.sv
// uart_apb_host_pkg: UART register map, STATUS bit indices, APB state and sequence-op enums, err_code values
package uart_apb_host_pkg;
  localparam logic [11:0] A_TX_DATA = 12'h000;
  localparam logic [11:0] A_RX_DATA = 12'h004;
  localparam logic [11:0] A_CFG = 12'h008;
  localparam logic [11:0] A_CTRL = 12'h00C;
  localparam logic [11:0] A_STATUS = 12'h010;
  localparam int ST_TX_DONE = 0;
  localparam int ST_RX_DONE = 1;
  localparam int ST_PAR_ERR = 2;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SLVERR = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  typedef enum logic [2:0] {RD_STAT_IDLE, WR_DATA, WR_START, RD_STAT_BUSY, WR_CFG, RD_STAT_RX, RD_RXDATA} seq_op_e;
  function automatic logic [11:0] op_addr(seq_op_e op);
    return op == WR_DATA ? A_TX_DATA : op == WR_START ? A_CTRL : op == WR_CFG ? A_CFG : op == RD_RXDATA ? A_RX_DATA : A_STATUS;
  endfunction
endpackage

// File: rtl/uart_apb_host_apb_master_port.sv
// apb_master_port: APB SETUP/ACCESS engine; ports: clk, reset, op_valid/addr/write/wdata in, done/rdata/slverr out, APB request out, APB response in
module apb_master_port
  import uart_apb_host_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              slverr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [3:0]        pstrb,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);
  apb_state_e state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic write_q, start;
  logic [31:0] wdata_q;
  assign done = state == ACCESS && pready;
  assign start = op_valid && (state == IDLE || done);
  assign rdata = prdata;
  assign slverr = pslverr;
  assign psel = state != IDLE;
  assign penable = state == ACCESS;
  assign pwrite = psel && write_q;
  assign pstrb = {3'b000, pwrite};
  assign paddr = psel ? addr_q : '0;
  assign pwdata = psel ? wdata_q : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr_q <= addr;
        write_q <= write;
        wdata_q <= wdata;
      end
    end
  end
  always_comb begin
    state_nx = start ? SETUP : state == SETUP ? ACCESS : done ? IDLE : state;
  end
endmodule

// File: rtl/uart_apb_host.sv
// uart_apb_host: APB initiator for the UART regs (cfg/tx/rx sequencer, poll timeout); ports: clk, reset, cfg_*, s_*, m_*, APB, err/err_code; RX polling via UART_APB_HOST_RX_EN
module uart_apb_host
  import uart_apb_host_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [4:0]        cfg_word,
  output logic              cfg_ready,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_par_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [3:0]        pstrb,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              err,
  output logic [1:0]        err_code
);
  seq_op_e op, op_nx;
  logic busy, go, done, slverr, ok, timeout, write, rx_hit, unused_rdata;
  logic [31:0] rdata, wdata;
  logic [7:0] tx_byte;
  logic [15:0] poll_cnt;
  logic [ADDR_W-1:0] addr;
`ifdef UART_APB_HOST_RX_EN
  localparam logic RX_POLL = 1'b1;
  logic prev_rx, par_q;
  assign rx_hit = rdata[ST_RX_DONE] && !prev_rx;
  assign m_valid = busy && done && !slverr && op == RD_RXDATA;
  assign m_data = m_valid ? rdata[7:0] : '0;
  assign m_par_err = m_valid && par_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rx <= 1'b1;
      par_q <= 1'b0;
    end else if (busy && done && !slverr && op == RD_STAT_RX) begin
      prev_rx <= rdata[ST_RX_DONE];
      par_q <= rdata[ST_PAR_ERR];
    end
  end
`else
  localparam logic RX_POLL = 1'b0;
  assign rx_hit = 1'b0;
  assign m_valid = 1'b0;
  assign m_data = '0;
  assign m_par_err = 1'b0;
`endif
  assign unused_rdata = ^rdata;
  assign ok = op == RD_STAT_IDLE ? rdata[ST_TX_DONE] : !rdata[ST_TX_DONE];
  assign timeout = (op == RD_STAT_IDLE || op == RD_STAT_BUSY) && !ok && poll_cnt + 16'd1 >= POLL_LIMIT;
  assign err = busy && done && (slverr || timeout);
  assign err_code = !err ? ERR_NONE : slverr ? ERR_SLVERR : ERR_TIMEOUT;
  assign cfg_ready = busy && done && op == WR_CFG;
  assign s_ready = !reset && !busy && !cfg_valid && s_valid;
  assign addr = ADDR_W'(op_addr(op_nx));
  assign write = op_nx == WR_DATA || op_nx == WR_START || op_nx == WR_CFG;
  assign wdata = op_nx == WR_DATA ? {24'b0, tx_byte} : op_nx == WR_START ? 32'd1 : op_nx == WR_CFG ? {27'b0, cfg_word} : '0;
  always_comb begin
    go = 1'b0;
    op_nx = op;
    if (!busy) begin
      go = cfg_valid || s_valid || RX_POLL;
      op_nx = cfg_valid ? WR_CFG : s_valid ? RD_STAT_IDLE : RD_STAT_RX;
    end else if (done && !err) begin
      case (op)
        RD_STAT_IDLE: begin go = 1'b1; op_nx = ok ? WR_DATA : RD_STAT_IDLE; end
        WR_DATA: begin go = 1'b1; op_nx = WR_START; end
        WR_START: begin go = 1'b1; op_nx = RD_STAT_BUSY; end
        RD_STAT_BUSY: go = !ok;
        RD_STAT_RX: begin go = rx_hit; op_nx = RD_RXDATA; end
        default: go = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      op <= RD_STAT_IDLE;
      tx_byte <= '0;
      poll_cnt <= '0;
    end else begin
      busy <= go || (busy && !done);
      if (go) begin
        op <= op_nx;
        poll_cnt <= busy && op_nx == op ? poll_cnt + 16'd1 : '0;
      end
      if (s_ready) tx_byte <= s_data;
    end
  end
  apb_master_port #(.ADDR_W(ADDR_W)) u_port (
    .clk(clk), .reset(reset), .op_valid(go), .addr(addr), .write(write), .wdata(wdata),
    .done(done), .rdata(rdata), .slverr(slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
endmodule

// File: tb/tb_uart_apb_host.sv
// tb_uart_apb_host: scoreboard bench for uart_apb_host with a scripted APB slave and cycle-stamped expectations
module tb_uart_apb_host;
  import uart_apb_host_pkg::*;
  typedef struct {int waits; logic [31:0] data; logic slverr;} rsp_t;
  typedef struct {int cyc; logic [48:0] bus;} xfer_t;
  typedef struct {int cyc; logic [1:0] kind; logic [8:0] val;} ev_t;
  localparam logic [1:0] EV_SRDY = 2'd0, EV_CFG = 2'd1, EV_ERR = 2'd2, EV_RX = 2'd3;
  logic clk = 1'b0, reset = 1'b1;
  logic cfg_valid, s_valid, cfg_ready, s_ready, m_valid, m_par_err;
  logic [4:0] cfg_word;
  logic [7:0] s_data, m_data;
  logic psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0, err;
  logic [3:0] pstrb;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata = '0;
  logic [1:0] err_code;
  rsp_t rq[$];
  xfer_t xq[$];
  ev_t eq[$];
  int cyc = 0, checks = 0, passes = 0;

  uart_apb_host #(.ADDR_W(12), .POLL_LIMIT(16'd4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_par_err(m_par_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic unexp(string n, logic [63:0] a);
    checks++;
    $display("FAIL %s: got %0h expected nothing", n, a);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rsp(int w, logic [31:0] d, logic e);
    rsp_t r;
    r.waits = w; r.data = d; r.slverr = e;
    rq.push_back(r);
  endtask

  task automatic xp(int c, logic w, logic [11:0] a, logic [31:0] d);
    xfer_t x;
    x.cyc = c;
    x.bus = {w, w ? 4'b0001 : 4'b0000, a, w ? d : 32'b0};
    xq.push_back(x);
  endtask

  task automatic ev(int c, logic [1:0] k, logic [8:0] v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    eq.push_back(e);
  endtask

  task automatic ev_chk(logic [1:0] k, logic [8:0] v);
    ev_t e;
    if (eq.size() == 0) unexp("event", {k, v});
    else begin
      e = eq.pop_front();
      chk("event", {k, v, 32'(cyc)}, {e.kind, e.val, 32'(e.cyc)});
    end
  endtask

  // scripted slave: drives the response for the current cycle just after each rising edge
  rsp_t cur;
  logic have = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (psel && penable) begin
      if (!have) begin
        if (rq.size() != 0) cur = rq.pop_front();
        else begin cur.waits = 0; cur.data = '0; cur.slverr = 1'b0; end
        have = 1'b1;
      end
      if (cur.waits > 0) begin
        cur.waits--;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
      end else begin
        pready = 1'b1; prdata = cur.data; pslverr = cur.slverr; have = 1'b0;
      end
    end else begin
      have = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    end
  end

  // monitor: pops expectations whenever the DUT completes a transfer or pulses a handshake/err/rx output
  logic in_wait = 1'b0;
  logic [46:0] hold;
  xfer_t xe;
  always @(negedge clk) begin
    if (reset) in_wait = 1'b0;
    else begin
      if (psel && penable) begin
        if (in_wait) chk("wait_stable", {psel, penable, pwrite, paddr, pwdata}, hold);
        hold = {psel, penable, pwrite, paddr, pwdata};
        in_wait = !pready;
        if (pready) begin
          if (xq.size() == 0) unexp("xfer", {pwrite, pstrb, paddr, pwdata});
          else begin
            xe = xq.pop_front();
            chk("xfer_bus", {pwrite, pstrb, paddr, pwdata}, xe.bus);
            chk("xfer_cyc", cyc, xe.cyc);
          end
        end
      end
      if (s_ready) ev_chk(EV_SRDY, 9'd0);
      if (cfg_ready) ev_chk(EV_CFG, 9'd0);
      if (err) ev_chk(EV_ERR, {7'd0, err_code});
      if (m_valid) ev_chk(EV_RX, {m_par_err, m_data});
    end
  end

  initial begin
    int k;
    logic sticky;
    cfg_valid = 1'b0; cfg_word = '0; s_valid = 1'b0; s_data = '0;
    tick(3);
    chk("reset_apb", {psel, penable, pwrite, pstrb, paddr, pwdata}, '0);
    chk("reset_flags", {cfg_ready, s_ready, m_valid, m_data, m_par_err, err, err_code}, '0);
`ifdef UART_APB_HOST_RX_EN
    k = cyc;
    rsp(0, 32'h0, 1'b0); rsp(0, 32'h2, 1'b0); rsp(0, 32'h3C, 1'b0);
    xp(k + 2, 1'b0, A_STATUS, 0); xp(k + 5, 1'b0, A_STATUS, 0); xp(k + 7, 1'b0, A_RX_DATA, 0);
    ev(k + 7, EV_RX, {1'b0, 8'h3C});
    reset = 1'b0;
    tick(8);
    reset = 1'b1;
    tick(2);
`else
    reset = 1'b0;
    tick(2);
    k = cyc;
    rsp(0, 0, 1'b0);
    xp(k + 2, 1'b1, A_CFG, 32'h0B); ev(k + 2, EV_CFG, 0);
    cfg_word = 5'b01011; cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0; cfg_word = '0;
    tick(5);
    k = cyc;
    rsp(0, 1, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b0);
    xp(k + 2, 1'b0, A_STATUS, 0); xp(k + 4, 1'b1, A_TX_DATA, 32'hA5); xp(k + 6, 1'b1, A_CTRL, 1); xp(k + 8, 1'b0, A_STATUS, 0);
    ev(k, EV_SRDY, 0);
    s_data = 8'hA5; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0; s_data = '0;
    tick(9);
    chk("tx_back_idle", {psel, penable}, 2'b00);
    k = cyc;
    rsp(0, 1, 1'b0); rsp(3, 0, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b0);
    xp(k + 2, 1'b0, A_STATUS, 0); xp(k + 7, 1'b1, A_TX_DATA, 32'h5A); xp(k + 9, 1'b1, A_CTRL, 1); xp(k + 11, 1'b0, A_STATUS, 0);
    ev(k, EV_SRDY, 0);
    s_data = 8'h5A; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    tick(12);
    k = cyc;
    repeat (4) rsp(0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) xp(k + 2 * i, 1'b0, A_STATUS, 0);
    ev(k, EV_SRDY, 0); ev(k + 8, EV_ERR, {7'd0, ERR_TIMEOUT});
    s_data = 8'h11; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    tick(10);
    chk("timeout_back_idle", {psel, penable}, 2'b00);
    k = cyc;
    rsp(0, 1, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b1);
    xp(k + 2, 1'b0, A_STATUS, 0); xp(k + 4, 1'b1, A_TX_DATA, 32'h22); xp(k + 6, 1'b1, A_CTRL, 1);
    ev(k, EV_SRDY, 0); ev(k + 6, EV_ERR, {7'd0, ERR_SLVERR});
    s_data = 8'h22; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    tick(8);
    k = cyc;
    rsp(0, 0, 1'b0); rsp(0, 1, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b0); rsp(0, 0, 1'b0);
    xp(k + 2, 1'b1, A_CFG, 32'h14); ev(k + 2, EV_CFG, 0); ev(k + 3, EV_SRDY, 0);
    xp(k + 5, 1'b0, A_STATUS, 0); xp(k + 7, 1'b1, A_TX_DATA, 32'h33); xp(k + 9, 1'b1, A_CTRL, 1); xp(k + 11, 1'b0, A_STATUS, 0);
    cfg_word = 5'b10100; cfg_valid = 1'b1; s_data = 8'h33; s_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    tick(3);
    s_valid = 1'b0;
    tick(10);
    k = cyc;
    rsp(10, 1, 1'b0);
    ev(k, EV_SRDY, 0);
    s_data = 8'h44; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    tick(1);
    chk("pre_reset_access", {psel, penable}, 2'b11);
    reset = 1'b1;
    tick(1);
    chk("midreset_apb", {psel, penable, pwrite, pstrb, paddr, pwdata}, '0);
    chk("midreset_flags", {cfg_ready, s_ready, m_valid, m_data, m_par_err, err, err_code}, '0);
    tick(2);
    reset = 1'b0;
    sticky = 1'b0;
    repeat (6) begin
      tick(1);
      sticky = sticky | psel;
    end
    chk("post_reset_quiet", sticky, 1'b0);
`endif
    chk("xfers_drained", xq.size(), 0);
    chk("events_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_apb_host.md
# uart_apb_host

APB initiator that drives the UART peripheral's register map on behalf of on-chip logic. It turns a configuration request and a byte stream (valid/ready) into APB transfers: it polls STATUS, writes TX_DATA, pulses CTRL.start, and optionally fetches received bytes. It sits between a local requester and the UART's APB slave port, sharing the UART's `clk` domain.

## Interface
- `ADDR_W`, 12: APB address width.
- `POLL_LIMIT`, 16'd4096: maximum STATUS reads per wait phase before timeout.
- `clk` in 1: single clock, shared with the UART.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1, `cfg_word` in 5 {parity_type, parity_en, stop_bit_num, data_bit_num[1:0]}, `cfg_ready` out 1: configuration request.
- `s_valid` in 1, `s_data` in 8, `s_ready` out 1: TX byte stream.
- `m_valid` out 1, `m_data` out 8, `m_par_err` out 1: RX byte output (see Configuration).
- `psel`, `penable`, `pwrite` out 1; `pstrb` out 4; `paddr` out ADDR_W; `pwdata` out 32: APB request.
- `prdata` in 32, `pready` in 1, `pslverr` in 1: APB response.
- `err` out 1, `err_code` out 2: one-cycle error pulse and cause (01 pslverr, 10 timeout).

## Operation
- Register map in package: TX_DATA 0x000, RX_DATA 0x004, CFG 0x008, CTRL 0x00C, STATUS 0x010 (bit0 tx_done, bit1 rx_done, bit2 par_err).
- APB FSM: IDLE -> SETUP (psel=1, penable=0) -> ACCESS (psel=1, penable=1, held until pready) -> SETUP of the next op in the sequence, or IDLE when the sequence is done. prdata and pslverr are sampled in the ACCESS cycle where pready=1.
- Writes: pwrite=1, pstrb=4'b0001, pwdata={24'b0, byte}. Reads: pwrite=0, pstrb=0, pwdata=0.
- Arbitration in IDLE only, fixed priority: cfg > tx > rx poll.
- CFG sequence: write CFG={27'b0, cfg_word}; `cfg_ready` pulses 1 cycle in the completing ACCESS cycle.
- TX sequence: `s_ready` pulses in the IDLE cycle of acceptance and `s_data` is latched. Then: poll STATUS until bit0=1 (WAIT_IDLE); write TX_DATA; write CTRL=1; poll STATUS until bit0=0 (WAIT_BUSY); return to IDLE.
- Timeout: a 16-bit poll counter clears on phase entry and increments per STATUS read. At POLL_LIMIT reads without success: `err`=1, `err_code`=10, the sequence is abandoned, and the FSM goes to IDLE.
- pslverr=1 on any transfer: `err`=1, `err_code`=01, the sequence is abandoned after that ACCESS cycle, and the FSM goes to IDLE.
- Request inputs sampled only in IDLE. Changes at any other time are ignored.

## Timing
- Reset values: psel, penable, pwrite = 0; pstrb = 0; paddr = 0; pwdata = 0; cfg_ready, s_ready, m_valid, m_data, m_par_err, err, err_code = 0. FSM in IDLE; poll counter 0.
- Reset asserted mid-transfer: all outputs take reset values on the next edge. The APB transfer is dropped, not completed.
- Each transfer takes 2 cycles when pready=1. Each wait state adds 1 cycle in ACCESS.
- CFG latency with pready=1: `cfg_ready` 2 cycles after the accept cycle.
- TX with the UART idle and pready=1: accept c0, STATUS c1–c2, TX_DATA c3–c4, CTRL c5–c6, then WAIT_BUSY reads from c7.
- Next request is sampled no earlier than the IDLE cycle after the sequence ends.
- `cfg_valid` and `s_valid` high in the same IDLE cycle: cfg wins; `s_valid` is accepted after the CFG sequence.

## Configuration
- `UART_APB_HOST_RX_EN` defined: with no cfg or tx request, IDLE issues a STATUS read.
  - A bit1 transition from 0 to 1, relative to the previous read, triggers a RX_DATA read.
  - On that read, `m_valid` pulses 1 cycle with `m_data`=prdata[7:0] and `m_par_err`=STATUS bit2 from the triggering read.
  - The previous-bit1 flag resets to 1.
- Undefined: no RX polling, the bus stays idle between requests, and `m_valid`, `m_data`, `m_par_err` are tied 0.

## Structure
- `uart_apb_host_pkg`: register address localparams, STATUS bit indices, APB state enum (IDLE/SETUP/ACCESS), sequence-op enum (RD_STAT_IDLE, WR_DATA, WR_START, RD_STAT_BUSY, WR_CFG, RD_STAT_RX, RD_RXDATA), err_code constants.
- One sub-module, `apb_master_port`. It takes op-valid, addr, write, wdata; returns done, rdata, slverr. It owns the SETUP/ACCESS FSM. The top holds the sequencer, arbiter and poll counter.

## Test plan
- Reset: hold `reset` 3 cycles mid-ACCESS -> all outputs 0 on the next edge; psel stays 0 until a new request.
- CFG: cfg_word=5'b01011, pready=1 -> write 0x008 data 0x0B, pstrb=0x1; `cfg_ready` pulse at cycle 2.
- TX: s_data=0xA5, STATUS returns 0x1 then 0x0 -> transfers in order: read 0x010, write 0x000=0xA5, write 0x00C=0x1, read 0x010; FSM returns to IDLE.
- Wait states: pready low for 3 ACCESS cycles on the TX_DATA write -> psel, penable, paddr, pwdata stable throughout; the transfer completes on the pready=1 cycle.
- Timeout/error:
  - POLL_LIMIT=4, STATUS always 0x0 -> exactly 4 reads, then `err` with `err_code`=10.
  - pslverr=1 on the CTRL write -> `err_code`=01 and no WAIT_BUSY read.
- RX (macro on): STATUS returns 0x0 then 0x2, RX_DATA=0x3C -> read 0x004; `m_valid` pulse with `m_data`=0x3C, `m_par_err`=0.
